// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: opcode/NOP constants shared with decode, queue entry type and predecode helper.
// Entry carries predecode flags only when FETCH_PREDECODE_EN is defined.
package fetch_queue_pkg;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
`ifdef FETCH_PREDECODE_EN
    logic jal;
    logic jalr;
    logic branch;
`endif
  } entry_t;
  function automatic entry_t make_entry(input logic [31:0] data, input logic [31:0] pc);
    entry_t e;
    e.data = data;
    e.pc = pc;
`ifdef FETCH_PREDECODE_EN
    e.jal = data[6:0] == OP_JAL;
    e.jalr = data[6:0] == OP_JALR;
    e.branch = data[6:0] == OP_BRANCH;
`endif
    return e;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two circular queue of fetched entries with push/pop/clear and occupancy count.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  entry_t        din,
  output entry_t        head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = mem[rd];
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch request generator with in-order response queue and flush/drop handling.
// Optional per-entry predecode outputs are enabled by defining FETCH_PREDECODE_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef FETCH_PREDECODE_EN
  ,
  output logic        inst_is_jal,
  output logic        inst_is_jalr,
  output logic        inst_is_branch,
  output logic        inst_is_jump
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [31:0] fetch_pc, resp_pc, hold_data, hold_pc;
  logic [CW-1:0] inflight, drop_cnt, count;
  logic full, empty, accept, dropping, push, pop;
  entry_t head;
  assign dropping = drop_cnt != '0;
  // Stale responses still owed by memory count against capacity so counters stay bounded.
  assign imem_req_valid = rst && !flush && !full &&
    ({1'b0, count} + {1'b0, inflight} + {1'b0, drop_cnt} < (CW+1)'(DEPTH));
  assign imem_req_addr = fetch_pc;
  assign accept = imem_req_valid && imem_req_ready;
  assign push = imem_resp_valid && !flush && !dropping;
  assign pop = inst_valid && inst_ready && !flush;
  assign inst_valid = !empty;
  assign inst = empty ? hold_data : head.data;
  assign inst_pc = empty ? hold_pc : head.pc;
  // Responses return in order, so the PC of the next kept response trails fetch_pc by the outstanding count.
  assign resp_pc = fetch_pc - {inflight, 2'b00};
`ifdef FETCH_PREDECODE_EN
  assign inst_is_jal = !empty && head.jal;
  assign inst_is_jalr = !empty && head.jalr;
  assign inst_is_branch = !empty && head.branch;
  assign inst_is_jump = inst_is_jal || inst_is_jalr || inst_is_branch;
`endif
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .clear(flush),
    .din(make_entry(imem_resp_data, resp_pc)),
    .head(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      hold_data <= NOP;
      hold_pc <= '0;
    end else begin
      if (flush) begin
        fetch_pc <= flush_pc & ~32'h3;
        inflight <= '0;
        drop_cnt <= drop_cnt + inflight - CW'(imem_resp_valid);
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        inflight <= inflight + CW'(accept) - CW'(imem_resp_valid && !dropping);
        drop_cnt <= drop_cnt - CW'(imem_resp_valid && dropping);
      end
      if (!empty) begin
        hold_data <= head.data;
        hold_pc <= head.pc;
      end
    end
  end
endmodule
